// File: rtl/dr_pkg.sv
// Shared types for the dual-rail sum capture stage: FSM states, rail codes
// and the per-pair code classifier.
package dr_pkg;

  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_F    = 2'b01;
  localparam logic [1:0] RAIL_T    = 2'b10;
  localparam logic [1:0] RAIL_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_NULL = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_OUT       = 2'd2,
    S_ERR       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAIR_NULL = 2'd0,
    PAIR_DATA = 2'd1,
    PAIR_ILL  = 2'd2
  } pair_cls_t;

  function automatic pair_cls_t classify(input logic t, input logic f);
    pair_cls_t c;
    case ({t, f})
      RAIL_NULL:      c = PAIR_NULL;
      RAIL_F, RAIL_T: c = PAIR_DATA;
      RAIL_ILL:       c = PAIR_ILL;
      default:        c = PAIR_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Bank of identical multi-flop synchronisers, one per asynchronous rail.
module dr_sync #(
  parameter int unsigned N      = 10,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stg [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/dr_sum_capture.sv
// Completion detector for a dual-rail adder chain: synchronises the sum and
// carry rails, runs the DATA/NULL four-phase handshake and hands off the sum.
module dr_sum_capture
  import dr_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sum_t,
  input  logic [WIDTH-1:0] sum_f,
  input  logic             cout_t,
  input  logic             cout_f,
  output logic             rfd,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       cap_cnt
);

  localparam int unsigned NP = WIDTH + 1;
  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t state, state_nxt;

  logic [2*NP-1:0] rails_sync;
  logic [NP-1:0]   s_t, s_f;
  logic [NP-1:0]   prev_t, prev_f;
  logic [SYNC_STAGES:0] fill;
  logic            cur_vld, prev_vld;

  logic            w_null, w_complete, w_ill;
  logic            word_eq, awaited, seen_ill, accept, ill_hit, capture;
  logic [CW-1:0]   stab_cnt, stab_nxt;
  logic [CW-1:0]   ill_cnt, ill_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  dr_sync #(
    .N      (2 * NP),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({cout_t, sum_t, cout_f, sum_f}),
    .q     (rails_sync)
  );

  assign s_t = rails_sync[2*NP-1:NP];
  assign s_f = rails_sync[NP-1:0];

  // Tracks how far post-reset samples have travelled through the
  // synchroniser so reset-state flop contents never count as observed rails.
  assign cur_vld  = fill[SYNC_STAGES-1];
  assign prev_vld = fill[SYNC_STAGES];

  always_comb begin
    w_null     = 1'b1;
    w_complete = 1'b1;
    w_ill      = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      case (classify(s_t[i], s_f[i]))
        PAIR_NULL: w_complete = 1'b0;
        PAIR_DATA: w_null     = 1'b0;
        default: begin
          w_null     = 1'b0;
          w_complete = 1'b0;
          w_ill      = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    word_eq  = prev_vld && (s_t == prev_t) && (s_f == prev_f);
    awaited  = 1'b0;
    seen_ill = 1'b0;
    if (cur_vld) begin
      if (state == S_WAIT_NULL) awaited = w_null;
      if (state == S_WAIT_DATA) awaited = w_complete;
      seen_ill = w_ill && ((state == S_WAIT_NULL) || (state == S_WAIT_DATA));
    end

    stab_nxt = '0;
    if (awaited) stab_nxt = word_eq ? sat_inc(stab_cnt) : CNT_ONE;

    ill_nxt = '0;
    if (seen_ill) ill_nxt = sat_inc(ill_cnt);

    ill_hit = seen_ill && (ill_nxt == CNT_MAX);
    accept  = awaited && (stab_nxt == CNT_MAX) && !ill_hit;
    capture = accept && (state == S_WAIT_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_WAIT_NULL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_NULL: begin
        if (ill_hit)     state_nxt = S_ERR;
        else if (accept) state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (ill_hit)     state_nxt = S_ERR;
        else if (accept) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_nxt = S_WAIT_NULL;
      end
      S_ERR: begin
        if (err_clr) state_nxt = S_WAIT_NULL;
      end
      default: state_nxt = S_WAIT_NULL;
    endcase
  end

  always_comb begin
    rfd       = 1'b0;
    out_valid = 1'b0;
    err       = 1'b0;
    case (state)
      S_WAIT_DATA: rfd       = 1'b1;
      S_OUT:       out_valid = 1'b1;
      S_ERR:       err       = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill     <= '0;
      prev_t   <= '0;
      prev_f   <= '0;
      stab_cnt <= '0;
      ill_cnt  <= '0;
      result   <= '0;
      cap_cnt  <= '0;
    end else begin
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
      prev_t   <= s_t;
      prev_f   <= s_f;
      stab_cnt <= stab_nxt;
      ill_cnt  <= ill_nxt;
      if (capture) begin
        result  <= s_t;
        cap_cnt <= cap_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dr_sum_capture.sv
// Directed bench for dr_sum_capture: handshake, backpressure, glitch
// rejection, illegal-code error, counter wrap and mid-operation reset.
module tb_dr_sum_capture;

  logic       clk;
  logic       rst_n;
  logic [3:0] sum_t, sum_f;
  logic       cout_t, cout_f;
  logic       rfd;
  logic [4:0] result;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       err_clr;
  logic [7:0] cap_cnt;

  int n_cmp;
  int n_fail;

  dr_sum_capture #(
    .WIDTH         (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_t     (sum_t),
    .sum_f     (sum_f),
    .cout_t    (cout_t),
    .cout_f    (cout_f),
    .rfd       (rfd),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr),
    .cap_cnt   (cap_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [3:0] t, input logic [3:0] f,
                       input logic ct, input logic cf);
    sum_t  = t;
    sum_f  = f;
    cout_t = ct;
    cout_f = cf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until the selected output is high, or -1.
  task automatic wait_sig(input int sel, input int limit, output int n);
    logic found;
    found = 1'b0;
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      if (!found) begin
        step();
        if ((sel == 0 && rfd === 1'b1) || (sel == 1 && out_valid === 1'b1) ||
            (sel == 2 && err === 1'b1)) begin
          found = 1'b1;
          n = k;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    out_ready = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    step(); step(); step();
    n_cmp++; if (rfd !== 1'b0) begin n_fail++; $display("FAIL reset_rfd: got %b expected 0", rfd); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (cap_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cap_cnt); end
    n_cmp++; if (result !== 5'd0) begin n_fail++; $display("FAIL reset_result: got %b expected 00000", result); end
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL reset_rfd_latency: got %0d expected 4", n); end
    n_cmp++; if (out_valid !== 1'b0 || err !== 1'b0 || cap_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_idle: got valid=%b err=%b cnt=%0d expected 0/0/0", out_valid, err, cap_cnt);
    end
  endtask

  task automatic test_capture();
    int n;
    out_ready = 1'b1;
    drive(4'b1010, 4'b0101, 1'b0, 1'b1);
    wait_sig(1, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL cap_latency: got %0d expected 4", n); end
    n_cmp++; if (result !== 5'b01010) begin n_fail++; $display("FAIL cap_result: got %b expected 01010", result); end
    n_cmp++; if (rfd !== 1'b0) begin n_fail++; $display("FAIL cap_rfd: got %b expected 0", rfd); end
    n_cmp++; if (cap_cnt !== 8'd1) begin n_fail++; $display("FAIL cap_cnt: got %0d expected 1", cap_cnt); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cap_one_cycle: got %b expected 0", out_valid); end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL cap_null_rfd: got %0d expected 4", n); end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    drive(4'b1010, 4'b0101, 1'b0, 1'b1);
    wait_sig(1, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", n); end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      step();
      n_cmp++; if (out_valid !== 1'b1 || rfd !== 1'b0 || result !== 5'b01010) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b rfd=%b result=%b expected 1/0/01010", k, out_valid, rfd, result);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || rfd !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got valid=%b rfd=%b expected 0/0", out_valid, rfd);
    end
    n_cmp++; if (cap_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 2", cap_cnt); end
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL bp_rfd_latency: got %0d expected 2", n); end
  endtask

  task automatic test_glitch();
    int n;
    drive(4'b0110, 4'b1001, 1'b1, 1'b0);
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gl_early0: got %b expected 0", out_valid); end
    drive(4'b0111, 4'b1000, 1'b1, 1'b0);
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gl_early1: got %b expected 0", out_valid); end
    drive(4'b0110, 4'b1001, 1'b1, 1'b0);
    wait_sig(1, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL gl_latency: got %0d expected 4", n); end
    n_cmp++; if (result !== 5'b10110) begin n_fail++; $display("FAIL gl_result: got %b expected 10110", result); end
    n_cmp++; if (cap_cnt !== 8'd3) begin n_fail++; $display("FAIL gl_cnt: got %0d expected 3", cap_cnt); end
    step(); step(); step(); step();
    n_cmp++; if (cap_cnt !== 8'd3 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL gl_single: got cnt=%0d valid=%b expected 3/0", cap_cnt, out_valid);
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL gl_null_rfd: got %0d expected 4", n); end
  endtask

  task automatic test_illegal();
    int n;
    drive(4'b0100, 4'b0111, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_early%0d: got %b expected 0", k, err); end
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    n_cmp++; if (err !== 1'b1 || rfd !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ill_enter: got err=%b rfd=%b valid=%b expected 1/0/0", err, rfd, out_valid);
    end
    step(); step(); step(); step(); step();
    n_cmp++; if (err !== 1'b1 || rfd !== 1'b0) begin
      n_fail++; $display("FAIL ill_sticky: got err=%b rfd=%b expected 1/0", err, rfd);
    end
    n_cmp++; if (cap_cnt !== 8'd3) begin n_fail++; $display("FAIL ill_cnt: got %0d expected 3", cap_cnt); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0 || rfd !== 1'b0) begin
      n_fail++; $display("FAIL ill_clear: got err=%b rfd=%b expected 0/0", err, rfd);
    end
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL ill_rfd_latency: got %0d expected 2", n); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    n_cmp++; if (rfd !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL ill_clr_noop: got rfd=%b err=%b expected 1/0", rfd, err);
    end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    logic [4:0] v;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL wr_rfd_start: got %0d expected 4", n); end
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = 5'(i);
      drive(v[3:0], ~v[3:0], v[4], ~v[4]);
      wait_sig(1, 20, n);
      n_cmp++; if (n !== 4 || result !== v) begin
        n_fail++; $display("FAIL wr_cap%0d: got n=%0d result=%b expected 4/%b", i, n, result, v);
      end
      if (i == 254) begin
        n_cmp++; if (cap_cnt !== 8'd255) begin n_fail++; $display("FAIL wr_cnt255: got %0d expected 255", cap_cnt); end
      end
      step();
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      wait_sig(0, 20, n);
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL wr_null%0d: got %0d expected 4", i, n); end
    end
    n_cmp++; if (cap_cnt !== 8'd0) begin n_fail++; $display("FAIL wr_wrap: got %0d expected 0", cap_cnt); end
    out_ready = 1'b0;
    drive(4'b1111, 4'b0000, 1'b1, 1'b0);
    wait_sig(1, 20, n);
    n_cmp++; if (n !== 4 || cap_cnt !== 8'd1 || result !== 5'b11111) begin
      n_fail++; $display("FAIL wr_last: got n=%0d cnt=%0d result=%b expected 4/1/11111", n, cap_cnt, result);
    end
    step(); step();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wr_hold: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || cap_cnt !== 8'd0 || rfd !== 1'b0 || result !== 5'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL wr_midreset: got valid=%b cnt=%0d rfd=%b result=%b err=%b expected 0/0/0/00000/0",
                         out_valid, cap_cnt, rfd, result, err);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    test_reset();
    test_capture();
    test_backpressure();
    test_glitch();
    test_illegal();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
